// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage pipeline register with per-stage valid bits, valid/ready
// backpressure, synchronous flush, global write enable and an occupancy count.
module pipe_reg_chain #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gwe,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] valid_nxt_s;
    logic [DEPTH-1:0] load_s;
    logic [DEPTH-1:0] src_valid_s;
    logic [WIDTH-1:0] src_data_s [DEPTH];
    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH:0]   acc_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;

    // A stage can take new data if any stage at or beyond it is empty, or the sink is ready.
    function automatic logic [DEPTH:0] accept_chain(input logic [DEPTH-1:0] v,
                                                    input logic             ordy);
        logic [DEPTH:0] a;
        logic           hole;
        a        = {(DEPTH + 1){1'b0}};
        a[DEPTH] = ordy;
        hole     = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hole = hole | ~v[i];
            a[i] = ordy | hole;
        end
        return a;
    endfunction

    function automatic logic [CW-1:0] pop_count(input logic [DEPTH-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_src
        if (i == 0) begin : g_head
            assign src_valid_s[i] = in_valid;
            assign src_data_s[i]  = in_data;
        end else begin : g_body
            assign src_valid_s[i] = valid_r[i-1];
            assign src_data_s[i]  = data_r[i-1];
        end
    end

    // Next-state: freeze on !gwe, squash on flush, otherwise advance every accepting stage.
    always_comb begin
        acc_s       = accept_chain(valid_r, out_ready);
        valid_nxt_s = valid_r;
        load_s      = {DEPTH{1'b0}};
        if (!gwe) begin
            valid_nxt_s = valid_r;
        end else if (flush) begin
            valid_nxt_s = {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (acc_s[i]) begin
                    valid_nxt_s[i] = src_valid_s[i];
                    load_s[i]      = src_valid_s[i];
                end else begin
                    valid_nxt_s[i] = valid_r[i];
                end
            end
        end
        count_nxt_s = pop_count(valid_nxt_s);
    end

    // Valid bits and occupancy count; count tracks the valid vector it is registered with.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Data registers load only when a valid item moves in, so bubbles leave old data in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load_s[i]) begin
                    data_r[i] <= src_data_s[i];
                end
            end
        end
    end

    assign in_ready  = gwe & ~flush & ~rst & acc_s[0];
    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
    assign count     = count_r;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (WIDTH=8, DEPTH=3): directed stimulus pushes
// expected items, a negedge monitor pops and compares on every output transfer.
module tb_pipe_reg_chain;

    logic       clk = 1'b0;
    logic       rst;
    logic       gwe;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] count;

    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .gwe       (gwe),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected item.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && gwe && !flush) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
            end else begin
                chk("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one item; check in_ready against the expected acceptance, push if accepted.
    task automatic offer(input logic [7:0] d, input logic accept, input string name);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk(name, {31'h0, in_ready}, {31'h0, accept});
        if (accept) exp_q.push_back(d);
    endtask

    task automatic drain(input int max_cycles);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < max_cycles; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d items left, expected 0", exp_q.size());
            exp_q.delete();
        end
        chk("count_after_drain", {30'h0, count}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; gwe = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Async reset mid-cycle discards an in-flight item
        offer(8'h55, 1'b1, "rst_pre_accept");
        tick(); in_valid = 1'b0;
        tick(); tick();
        chk("rst_pre_valid", {31'h0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_count", {30'h0, count}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_out_data", {24'h0, out_data}, 32'h00);
        exp_q.delete();
        tick();
        rst = 1'b0;

        // Latency: item lands in stage 0 on the handshake edge, stage 2 two edges later
        out_ready = 1'b1;
        offer(8'hA5, 1'b1, "lat_accept");
        tick(); in_valid = 1'b0;
        chk("lat_e1_valid", {31'h0, out_valid}, 32'd0);
        chk("lat_e1_count", {30'h0, count}, 32'd1);
        tick();
        chk("lat_e2_valid", {31'h0, out_valid}, 32'd0);
        tick();
        chk("lat_e3_valid", {31'h0, out_valid}, 32'd1);
        drain(10);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            offer(8'(k), 1'b1, "stream_in_ready");
            tick();
            if (k >= 3) chk("stream_out_valid", {31'h0, out_valid}, 32'd1);
            if (k == 4) chk("stream_count", {30'h0, count}, 32'd3);
        end
        drain(10);

        // Backpressure: fill, refuse, then simultaneous in/out on a full chain
        out_ready = 1'b0;
        offer(8'h10, 1'b1, "bp_acc0"); tick();
        offer(8'h11, 1'b1, "bp_acc1"); tick();
        offer(8'h12, 1'b1, "bp_acc2"); tick();
        offer(8'h13, 1'b0, "bp_refuse");
        chk("bp_count_full", {30'h0, count}, 32'd3);
        out_ready = 1'b1;
        offer(8'h13, 1'b1, "bp_full_passthru");
        tick();
        chk("bp_count_after", {30'h0, count}, 32'd3);
        drain(10);

        // Bubble collapse under stall
        out_ready = 1'b0;
        offer(8'h20, 1'b1, "bub_acc20"); tick();
        in_valid = 1'b0;
        tick(); tick();
        offer(8'h21, 1'b1, "bub_acc21"); tick();
        offer(8'h22, 1'b1, "bub_acc22"); tick();
        chk("bub_count", {30'h0, count}, 32'd3);
        offer(8'h23, 1'b0, "bub_refuse");
        drain(10);

        // gwe=0 freezes everything, flush included
        out_ready = 1'b0;
        offer(8'h30, 1'b1, "gwe_acc30"); tick();
        offer(8'h31, 1'b1, "gwe_acc31"); tick();
        gwe = 1'b0; flush = 1'b1; out_ready = 1'b1;
        offer(8'h3F, 1'b0, "gwe_in_ready");
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("gwe_count", {30'h0, count}, 32'd2);
            chk("gwe_out_valid", {31'h0, out_valid}, 32'd0);
        end
        gwe = 1'b1; flush = 1'b0;
        drain(10);

        // Flush a full chain; the offered item must not enter
        out_ready = 1'b0;
        offer(8'h50, 1'b1, "fl_acc0"); tick();
        offer(8'h51, 1'b1, "fl_acc1"); tick();
        offer(8'h52, 1'b1, "fl_acc2"); tick();
        chk("fl_count_full", {30'h0, count}, 32'd3);
        flush = 1'b1; out_ready = 1'b1;
        offer(8'h40, 1'b0, "fl_in_ready");
        tick();
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("fl_count", {30'h0, count}, 32'd0);
        chk("fl_out_valid", {31'h0, out_valid}, 32'd0);
        repeat (6) tick();
        chk("fl_count_end", {30'h0, count}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
